// File: rtl/cen_frac_gen.sv
// Fractional clock-enable generator: a phase accumulator yields an average tick rate of Num/Den
// per Clk, and each accepted tick becomes a PULSE_W-cycle Cen level for downstream 74163-style chains.
module cen_frac_gen #(
  parameter int unsigned ACC_W    = 10,
  parameter int unsigned PULSE_W  = 2,
  parameter int unsigned NUM_INIT = 1,
  parameter int unsigned DEN_INIT = 8
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Enable,
  input  logic             Restart,
  input  logic [ACC_W-1:0] Num,
  input  logic [ACC_W-1:0] Den,
  output logic             Cen,
  output logic             Cen_rise,
  output logic             Cen_fall,
  output logic [15:0]      Tick_cnt,
  output logic             Overrun,
  output logic             Cfg_err
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_W);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] num_q, num_d;
  logic [ACC_W-1:0] den_q, den_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cen_rise_q, cen_rise_d;
  logic             cen_fall_q, cen_fall_d;
  logic [15:0]      tick_cnt_q, tick_cnt_d;
  logic             overrun_q, overrun_d;

  logic [ACC_W:0]   sum;
  logic [ACC_W:0]   diff;
  logic             cfg_err;
  logic             advance;
  logic             tick;
  logic             accept;

  assign cfg_err = (den_q == '0) || (num_q > den_q);

  always_comb begin
    // NOTE: every always_comb target gets a default first so no path can infer a latch.
    acc_d      = acc_q;
    num_d      = num_q;
    den_d      = den_q;
    cnt_d      = cnt_q;
    cen_rise_d = 1'b0;
    cen_fall_d = 1'b0;
    tick_cnt_d = tick_cnt_q;
    overrun_d  = overrun_q;

    // One extra bit so acc + Num cannot wrap before the compare against Den.
    sum     = {1'b0, acc_q} + {1'b0, num_q};
    diff    = sum - {1'b0, den_q};
    advance = Enable && !cfg_err;
    tick    = advance && (sum >= {1'b0, den_q});
    accept  = tick && (cnt_q == '0);

    if (Restart) begin
      acc_d      = '0;
      cnt_d      = '0;
      overrun_d  = 1'b0;
      num_d      = Num;
      den_d      = Den;
      cen_fall_d = (cnt_q != '0);
    end else begin
      if (advance) begin
        acc_d = tick ? diff[ACC_W-1:0] : sum[ACC_W-1:0];
      end

      // A tick landing on an active pulse is dropped rather than merged, so
      // Cen always has at least one low cycle between pulses.
      if (accept) begin
        cnt_d = PULSE_LOAD;
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end

      if (tick && (cnt_q != '0)) begin
        overrun_d = 1'b1;
      end

      cen_rise_d = accept;
      cen_fall_d = (cnt_q == CNT_W'(1));
      tick_cnt_d = tick_cnt_q + 16'(accept);
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      acc_q      <= '0;
      num_q      <= ACC_W'(NUM_INIT);
      den_q      <= ACC_W'(DEN_INIT);
      cnt_q      <= '0;
      cen_rise_q <= 1'b0;
      cen_fall_q <= 1'b0;
      tick_cnt_q <= '0;
      overrun_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      acc_q      <= acc_d;
      num_q      <= num_d;
      den_q      <= den_d;
      cnt_q      <= cnt_d;
      cen_rise_q <= cen_rise_d;
      cen_fall_q <= cen_fall_d;
      tick_cnt_q <= tick_cnt_d;
      overrun_q  <= overrun_d;
    end
  end

  assign Cen      = (cnt_q != '0);
  assign Cen_rise = cen_rise_q;
  assign Cen_fall = cen_fall_q;
  assign Tick_cnt = tick_cnt_q;
  assign Overrun  = overrun_q;
  assign Cfg_err  = cfg_err;

endmodule

// File: tb/tb_cen_frac_gen.sv
// Directed bench for cen_frac_gen: hand-derived Cen/rise/fall timelines for
// default config, fractional rate, Num==Den overrun, Enable gaps, Restart, bad config and async reset.
module tb_cen_frac_gen;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        Enable;
  logic        Restart;
  logic [9:0]  Num;
  logic [9:0]  Den;
  logic        Cen;
  logic        Cen_rise;
  logic        Cen_fall;
  logic [15:0] Tick_cnt;
  logic        Overrun;
  logic        Cfg_err;

  int total = 0;
  int bad   = 0;

  cen_frac_gen #(
    .ACC_W   (10),
    .PULSE_W (2),
    .NUM_INIT(1),
    .DEN_INIT(8)
  ) dut (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .Enable  (Enable),
    .Restart (Restart),
    .Num     (Num),
    .Den     (Den),
    .Cen     (Cen),
    .Cen_rise(Cen_rise),
    .Cen_fall(Cen_fall),
    .Tick_cnt(Tick_cnt),
    .Overrun (Overrun),
    .Cfg_err (Cfg_err)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic cycle();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic do_restart(input logic [9:0] n, input logic [9:0] d);
    Restart = 1'b1;
    Num     = n;
    Den     = d;
    cycle();
    Restart = 1'b0;
  endtask

  function automatic logic [31:0] flags();
    return {29'd0, Cen, Cen_rise, Cen_fall};
  endfunction

  function automatic logic [31:0] mk(input bit c, input bit r, input bit f);
    return {29'd0, c, r, f};
  endfunction

  initial begin
    int rises;
    int last_rise;
    int min_gap;
    int max_gap;
    int cen_cycles;
    logic [15:0] base;

    Rst_n   = 1'b0;
    Enable  = 1'b1;
    Restart = 1'b0;
    Num     = '0;
    Den     = '0;

    #23;
    check("rst flags", flags(), mk(0, 0, 0));
    check("rst tick_cnt", 32'(Tick_cnt), 32'd0);
    check("rst overrun", 32'(Overrun), 32'd0);
    check("rst cfg_err", 32'(Cfg_err), 32'd0);
    @(negedge Clk);
    Rst_n = 1'b1;

    // 1/8 rate: ticks at 7/15/23, pulses at 8-9/16-17/24-25.
    for (int c = 0; c < 28; c++) begin
      check($sformatf("t1 flags c%0d", c), flags(),
            mk(c inside {8, 9, 16, 17, 24, 25}, c inside {8, 16, 24}, c inside {10, 18, 26}));
      cycle();
    end
    check("t1 tick_cnt", 32'(Tick_cnt), 32'd3);
    check("t1 overrun", 32'(Overrun), 32'd0);

    // 3/16 rate: 30 pulses in 160 cycles, gaps of 5 or 6.
    do_restart(10'd3, 10'd16);
    check("t2 cfg_err", 32'(Cfg_err), 32'd0);
    base      = Tick_cnt;
    rises     = 0;
    last_rise = -1;
    min_gap   = 1000;
    max_gap   = 0;
    for (int i = 1; i <= 160; i++) begin
      cycle();
      if (Cen_rise) begin
        rises++;
        if (last_rise >= 0) begin
          if (i - last_rise < min_gap) min_gap = i - last_rise;
          if (i - last_rise > max_gap) max_gap = i - last_rise;
        end
        last_rise = i;
      end
    end
    check("t2 rises", 32'(rises), 32'd30);
    check("t2 min gap", 32'(min_gap), 32'd5);
    check("t2 max gap", 32'(max_gap), 32'd6);
    check("t2 tick_cnt delta", 32'(Tick_cnt - base), 32'd30);
    check("t2 overrun", 32'(Overrun), 32'd0);

    // Num==Den: Cen 1,1,0 repeating, Overrun from the first dropped tick.
    do_restart(10'd4, 10'd4);
    check("t3 cfg_err", 32'(Cfg_err), 32'd0);
    for (int c = 0; c < 12; c++) begin
      check($sformatf("t3 cen c%0d", c), 32'(Cen), 32'((c >= 1) && (((c - 1) % 3) < 2)));
      check($sformatf("t3 overrun c%0d", c), 32'(Overrun), 32'(c >= 2));
      cycle();
    end
    do_restart(10'd1, 10'd8);
    check("t3 overrun cleared", 32'(Overrun), 32'd0);

    // Enable low in cycles 8..27: pulse finishes, phase shifts by exactly 20.
    for (int c = 0; c < 41; c++) begin
      Enable = !((c >= 8) && (c < 28));
      check($sformatf("t4 flags c%0d", c), flags(),
            mk(c inside {8, 9, 36, 37}, c inside {8, 36}, c inside {10, 38}));
      cycle();
    end
    Enable = 1'b1;

    // Restart on the first high cycle of Cen.
    do_restart(10'd1, 10'd8);
    repeat (8) cycle();
    check("t5 rise before restart", flags(), mk(1, 1, 0));
    do_restart(10'd1, 10'd4);
    check("t5 after restart", flags(), mk(0, 0, 1));
    for (int c = 1; c < 7; c++) begin
      cycle();
      check($sformatf("t5 flags c%0d", c), flags(),
            mk(c inside {4, 5}, c == 4, c == 6));
    end

    // Invalid configurations hold the generator idle.
    do_restart(10'd1, 10'd0);
    check("t6 cfg_err den0", 32'(Cfg_err), 32'd1);
    cen_cycles = 0;
    repeat (20) begin
      cycle();
      cen_cycles += int'(Cen);
    end
    check("t6 cen den0", 32'(cen_cycles), 32'd0);
    do_restart(10'd9, 10'd8);
    check("t6 cfg_err num>den", 32'(Cfg_err), 32'd1);
    cen_cycles = 0;
    repeat (20) begin
      cycle();
      cen_cycles += int'(Cen);
    end
    check("t6 cen num>den", 32'(cen_cycles), 32'd0);

    // Async reset in the middle of a pulse.
    do_restart(10'd1, 10'd8);
    check("t7 cfg_err ok", 32'(Cfg_err), 32'd0);
    repeat (8) cycle();
    check("t7 cen before reset", 32'(Cen), 32'd1);
    #2 Rst_n = 1'b0;
    #1;
    check("t7 async flags", flags(), mk(0, 0, 0));
    check("t7 async tick_cnt", 32'(Tick_cnt), 32'd0);
    check("t7 async overrun", 32'(Overrun), 32'd0);
    check("t7 async cfg_err", 32'(Cfg_err), 32'd0);
    @(negedge Clk);
    Rst_n = 1'b1;
    repeat (7) cycle();
    check("t7 cen c7", 32'(Cen), 32'd0);
    cycle();
    check("t7 resume flags c8", flags(), mk(1, 1, 0));
    check("t7 resume tick_cnt", 32'(Tick_cnt), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cen_frac_gen.md
Name: cen_frac_gen

Overview:
Fractional clock-enable generator that feeds the Cen input of the synchronous 74163-style counter chains used for video timing and sound dividers.
- Derives an average rate of Num/Den from the master Clk with a phase accumulator.
- Emits Cen as a level pulse PULSE_W cycles wide, so the downstream rising-edge detector sees one clean edge per tick.
- Also provides rise/fall strobes, a pulse counter and overrun/config-error flags for debug.

Parameters:
ACC_W, 10, width of Num, Den and the accumulator.
PULSE_W, 2, Cen high time in Clk cycles (1..15).
NUM_INIT, 1, Num value loaded at reset.
DEN_INIT, 8, Den value loaded at reset (default is 48 MHz to 6 MHz).

Ports:
Clk  in  1  master clock; all logic on rising edge.
Rst_n  in  1  asynchronous active-low reset.
Enable  in  1  accumulator advances only while high.
Restart  in  1  synchronous phase restart and config load.
Num  in  ACC_W  numerator; sampled only on Restart.
Den  in  ACC_W  denominator; sampled only on Restart.
Cen  out  1  enable level to downstream counters; high PULSE_W cycles per tick.
Cen_rise  out  1  one-cycle strobe, high in the first cycle Cen is high.
Cen_fall  out  1  one-cycle strobe, high in the first cycle Cen is low after a pulse.
Tick_cnt  out  16  count of emitted pulses; wraps 0xFFFF to 0.
Overrun  out  1  sticky; a tick was dropped because a pulse was still active.
Cfg_err  out  1  high while latched Den==0 or Num>Den.

Behaviour:
- Reset (async, Rst_n=0), values that apply immediately:
  - acc=0, pulse timer cnt=0.
  - Cen, Cen_rise, Cen_fall = 0; Tick_cnt=0; Overrun=0.
  - Num_r=NUM_INIT, Den_r=DEN_INIT.
  - Cfg_err reflects the init values.
- Registers and outputs:
  - All outputs are registered or decoded from registers only; no combinational path from inputs.
  - Cen = (cnt != 0).
  - Cfg_err = (Den_r==0) || (Num_r>Den_r).
- Per cycle, with Restart=0, Enable=1 and Cfg_err=0:
  - sum = acc + Num_r, computed ACC_W+1 bits wide.
  - If sum >= Den_r: acc <= sum - Den_r and tick=1.
  - Otherwise: acc <= sum and tick=0.
- Tick handling, for a tick evaluated in cycle k:
  - If cnt==0 in cycle k: cnt <= PULSE_W, so Cen is high in cycles k+1..k+PULSE_W. Cen_rise=1 in cycle k+1. Tick_cnt increments in cycle k+1.
  - If cnt!=0 in cycle k: the tick is dropped, Overrun <= 1, and the accumulator still advances.
- Pulse timer and spacing:
  - With no new accepted tick, cnt decrements by 1 per cycle while nonzero.
  - Cen_fall=1 in the first cycle where cnt==0 and the previous cycle's cnt==1.
  - Cen is therefore always low for at least one cycle between pulses. The downstream counter must never see a merged pulse.
- Enable=0:
  - acc is frozen and no ticks occur.
  - An in-flight pulse completes normally.
- Cfg_err=1:
  - Treated as Enable=0; acc is frozen.
- Restart=1 (priority over Enable):
  - Next cycle: acc=0, cnt=0 (Cen forced low, even mid-pulse), Overrun=0.
  - Num_r=Num and Den_r=Den.
  - Tick_cnt is kept; Cen_rise=0.
  - Cen_fall=1 if Cen was high.
  - First tick evaluation after Restart uses the new Num_r/Den_r.
- Num==Den: tick every cycle; Cen runs PULSE_W high, 1 low, and Overrun sets.
- Reset mid-pulse: Cen drops asynchronously. After Rst_n rises, operation resumes from acc=0.

Test Plan:
- NUM_INIT=1, DEN_INIT=8, PULSE_W=2, Enable=1 from cycle 0 after reset release -> ticks in cycles 7, 15, 23; Cen high in cycles 8-9, 16-17, 24-25; Cen_rise in 8/16/24; Cen_fall in 10/18; Overrun=0.
- Restart with Num=3, Den=16, then run 160 enabled cycles -> exactly 30 Cen rising edges; pulse spacing is 5 or 6 cycles only; Tick_cnt advances by 30.
- Restart with Num=4, Den=4, PULSE_W=2 -> Cen pattern 1,1,0 repeating; Overrun=1 from the first dropped tick; Restart clears Overrun next cycle.
- Enable low for 20 cycles mid-sequence -> acc frozen, in-flight pulse finishes, no new Cen; the pulse phase resumes exactly where it left off once Enable is high again.
- Restart asserted on the first high cycle of Cen -> Cen low next cycle, Cen_fall=1, acc=0, next tick occurs Den/Num cycles later.
- Restart with Den=0, then with Num=9/Den=8 -> Cfg_err=1, no Cen activity. Rst_n pulsed low mid-pulse -> Cen=0 without a clock edge; all outputs at their reset values.
